nn_avalon_csr_bridge: RTL and testbench

- Parametrised Avalon-MM slave between the Nios/HPS bus and one neural-net inference core. Generalises the fixed 2-input/1-output interface to NUM_IN inputs and NUM_OUT outputs.
- Adds a control/status register (CSR), a start/done handshake FSM, output capture, a cycle counter, a timeout, error flags and an interrupt.
- The core is instantiated by the parent. This block only drives and observes the core's handshake and data ports.

---
 rtl/nn_bridge_pkg.sv | 41 ++++
 rtl/nn_avalon_csr_bridge_if.sv | 22 ++
 rtl/nn_run_ctrl.sv | 111 +++++++++++
 rtl/nn_avalon_csr_bridge.sv | 134 +++++++++++++
 tb/tb_nn_avalon_csr_bridge.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/nn_bridge_pkg.sv
// Shared constants, FSM state type and sign-extension helper for the NN CSR bridge.
package nn_bridge_pkg;

    // Word offsets of the fixed CSRs; input registers start at IN_BASE.
    localparam int unsigned ADDR_CTRL   = 0;
    localparam int unsigned ADDR_STATUS = 1;
    localparam int unsigned ADDR_CYCLES = 2;
    localparam int unsigned IN_BASE     = 4;

    // CTRL bit positions.
    localparam int unsigned CTRL_START  = 0;
    localparam int unsigned CTRL_IRQ_EN = 1;
    localparam int unsigned CTRL_CLR    = 2;

    // STATUS bit positions.
    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_DONE    = 1;
    localparam int unsigned STAT_TIMEOUT = 2;
    localparam int unsigned STAT_ERR     = 3;

    // Widest result the sign-extension helper can produce.
    localparam int unsigned SEXT_MAX_W = 64;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } run_state_t;

    // Sign-extend the low 'width' bits of value to SEXT_MAX_W bits.
    function automatic logic [SEXT_MAX_W-1:0] sign_extend(
        input logic [SEXT_MAX_W-1:0] value,
        input int unsigned           width
    );
        int unsigned             sh;
        logic [SEXT_MAX_W-1:0]   shifted;
        sh      = SEXT_MAX_W - width;
        shifted = value << sh;
        return SEXT_MAX_W'($signed(shifted) >>> sh);
    endfunction

endpackage

// File: rtl/nn_avalon_csr_bridge_if.sv
// Avalon-MM slave bus bundle between the host and the NN CSR bridge.
interface nn_avalon_csr_bridge_if #(
    parameter int unsigned W      = 32,
    parameter int unsigned ADDR_W = 5
);
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write;
    logic              read;
    logic [W-1:0]      writedata;
    logic [W-1:0]      readdata;

    modport master (
        output address, chipselect, write, read, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write, read, writedata,
        output readdata
    );
endinterface

// File: rtl/nn_run_ctrl.sv
// Start/done handshake FSM with cycle counter, timeout, sticky flags and interrupt.
module nn_run_ctrl
    import nn_bridge_pkg::*;
#(
    parameter int unsigned W              = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         ctrl_wr,
    input  logic         wr_start,
    input  logic         wr_irq_en,
    input  logic         wr_clr,
    input  logic         in_wr,
    input  logic         core_done,
    output logic         core_start,
    output logic         busy,
    output logic         done,
    output logic         timeout,
    output logic         err,
    output logic         irq_en,
    output logic         irq,
    output logic [W-1:0] cycles,
    output logic         capture_c
);

    run_state_t   state_q, state_d;
    logic [W-1:0] count_q, count_d, count_inc_c;
    logic [W-1:0] cycles_d;
    logic         done_d, timeout_d, err_d, irq_en_d, irq_d, start_d;

    assign busy = (state_q == ST_RUN);

    // State and flag registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            cycles     <= '0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            err        <= 1'b0;
            irq_en     <= 1'b0;
            irq        <= 1'b0;
            core_start <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            cycles     <= cycles_d;
            done       <= done_d;
            timeout    <= timeout_d;
            err        <= err_d;
            irq_en     <= irq_en_d;
            irq        <= irq_d;
            core_start <= start_d;
        end
    end

    // Next-state logic; flag sets are evaluated after CLR so a coincident set wins.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        cycles_d    = cycles;
        done_d      = done;
        timeout_d   = timeout;
        err_d       = err;
        irq_en_d    = irq_en;
        start_d     = 1'b0;
        capture_c   = 1'b0;
        count_inc_c = (&count_q) ? count_q : count_q + W'(1);

        if (ctrl_wr) begin
            irq_en_d = wr_irq_en;
            if (wr_clr) begin
                done_d    = 1'b0;
                timeout_d = 1'b0;
                err_d     = 1'b0;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (ctrl_wr && wr_start) begin
                    start_d = 1'b1;
                    count_d = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                count_d = count_inc_c;
                if ((ctrl_wr && wr_start) || in_wr) begin
                    err_d = 1'b1;
                end
                if (core_done) begin
                    capture_c = 1'b1;
                    done_d    = 1'b1;
                    cycles_d  = count_q;
                    state_d   = ST_IDLE;
                end else if ((TIMEOUT_CYCLES != 0) &&
                             (count_inc_c == W'(TIMEOUT_CYCLES))) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        irq_d = done_d & irq_en_d;
    end

endmodule

// File: rtl/nn_avalon_csr_bridge.sv
// Avalon-MM CSR bridge to one NN inference core: register file, read mux and run control.
module nn_avalon_csr_bridge
    import nn_bridge_pkg::*;
#(
    parameter int unsigned W              = 32,
    parameter int unsigned ADDR_W         = 5,
    parameter int unsigned BIT_WIDTH      = 9,
    parameter int unsigned FRACTION_WIDTH = 4,
    parameter int unsigned NUM_IN         = 2,
    parameter int unsigned NUM_OUT        = 1,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                          clock,
    input  logic                          reset,
    nn_avalon_csr_bridge_if.slave         bus,
    output logic                          irq,
    output logic                          core_start,
    input  logic                          core_done,
    output logic [NUM_IN*BIT_WIDTH-1:0]   core_inputs,
    input  logic [NUM_OUT*BIT_WIDTH-1:0]  core_outputs
);

    localparam int unsigned OUT_BASE = IN_BASE + NUM_IN;

    // Reject parameter sets the address map or data path cannot hold.
    if ((IN_BASE + NUM_IN + NUM_OUT > (1 << ADDR_W)) || (W > SEXT_MAX_W) ||
        (BIT_WIDTH > W) || (FRACTION_WIDTH >= BIT_WIDTH)) begin : g_param_check
        $error("nn_avalon_csr_bridge: unsupported parameter combination");
    end

    logic                         wr_en_c, ctrl_wr_c, in_wr_c, capture_c;
    logic                         busy, done, timeout, err, irq_en;
    logic [W-1:0]                 cycles;
    logic [W-1:0]                 rd_data_c;
    logic [NUM_OUT*BIT_WIDTH-1:0] out_q;
    logic                         unused_wdata_c;

    assign unused_wdata_c = ^bus.writedata[W-1:BIT_WIDTH];

    assign wr_en_c   = bus.chipselect & bus.write;
    assign ctrl_wr_c = wr_en_c && (bus.address == ADDR_W'(ADDR_CTRL));

    // Any write landing on an input register.
    always_comb begin
        in_wr_c = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (wr_en_c && (bus.address == ADDR_W'(IN_BASE + i))) begin
                in_wr_c = 1'b1;
            end
        end
    end

    nn_run_ctrl #(
        .W              (W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_run_ctrl (
        .clock      (clock),
        .reset      (reset),
        .ctrl_wr    (ctrl_wr_c),
        .wr_start   (bus.writedata[CTRL_START]),
        .wr_irq_en  (bus.writedata[CTRL_IRQ_EN]),
        .wr_clr     (bus.writedata[CTRL_CLR]),
        .in_wr      (in_wr_c),
        .core_done  (core_done),
        .core_start (core_start),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .err        (err),
        .irq_en     (irq_en),
        .irq        (irq),
        .cycles     (cycles),
        .capture_c  (capture_c)
    );

    // Input registers, frozen while a run is in progress.
    always_ff @(posedge clock) begin
        if (reset) begin
            core_inputs <= '0;
        end else if (wr_en_c && !busy) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (bus.address == ADDR_W'(IN_BASE + i)) begin
                    core_inputs[i*BIT_WIDTH +: BIT_WIDTH] <= bus.writedata[BIT_WIDTH-1:0];
                end
            end
        end
    end

    // Capture core results on a completed run.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_q <= '0;
        end else if (capture_c) begin
            out_q <= core_outputs;
        end
    end

    // Read mux; unmapped and reserved addresses return zero.
    always_comb begin
        rd_data_c = '0;
        if (bus.address == ADDR_W'(ADDR_CTRL)) begin
            rd_data_c[CTRL_IRQ_EN] = irq_en;
        end else if (bus.address == ADDR_W'(ADDR_STATUS)) begin
            rd_data_c[STAT_BUSY]    = busy;
            rd_data_c[STAT_DONE]    = done;
            rd_data_c[STAT_TIMEOUT] = timeout;
            rd_data_c[STAT_ERR]     = err;
        end else if (bus.address == ADDR_W'(ADDR_CYCLES)) begin
            rd_data_c = cycles;
        end
        for (int i = 0; i < NUM_IN; i++) begin
            if (bus.address == ADDR_W'(IN_BASE + i)) begin
                rd_data_c = W'(sign_extend(
                    SEXT_MAX_W'(core_inputs[i*BIT_WIDTH +: BIT_WIDTH]), BIT_WIDTH));
            end
        end
        for (int j = 0; j < NUM_OUT; j++) begin
            if (bus.address == ADDR_W'(OUT_BASE + j)) begin
                rd_data_c = W'(sign_extend(
                    SEXT_MAX_W'(out_q[j*BIT_WIDTH +: BIT_WIDTH]), BIT_WIDTH));
            end
        end
    end

    // Registered read data with fixed latency of one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.readdata <= '0;
        end else if (bus.chipselect && bus.read) begin
            bus.readdata <= rd_data_c;
        end
    end

endmodule

// File: tb/tb_nn_avalon_csr_bridge.sv
// Directed bench for nn_avalon_csr_bridge: a 2-in/1-out instance with a short timeout
// and an 8-in/3-out instance, driven on negedges and sampled on negedges.
module tb_nn_avalon_csr_bridge;

    logic        clk;
    logic        rst_a, rst_b;
    logic        irq_a, irq_b;
    logic        core_start_a, core_start_b;
    logic        core_done_a, core_done_b;
    logic [17:0] core_inputs_a;
    logic [8:0]  core_outputs_a;
    logic [71:0] core_inputs_b;
    logic [26:0] core_outputs_b;

    int checks = 0;
    int errors = 0;

    logic [8:0]  vin  [8];
    logic [31:0] vexp [8];

    nn_avalon_csr_bridge_if #(.W(32), .ADDR_W(5)) bus_a ();
    nn_avalon_csr_bridge_if #(.W(32), .ADDR_W(5)) bus_b ();

    nn_avalon_csr_bridge #(
        .W(32), .ADDR_W(5), .BIT_WIDTH(9), .FRACTION_WIDTH(4),
        .NUM_IN(2), .NUM_OUT(1), .TIMEOUT_CYCLES(16)
    ) dut_a (
        .clock        (clk),
        .reset        (rst_a),
        .bus          (bus_a),
        .irq          (irq_a),
        .core_start   (core_start_a),
        .core_done    (core_done_a),
        .core_inputs  (core_inputs_a),
        .core_outputs (core_outputs_a)
    );

    nn_avalon_csr_bridge #(
        .W(32), .ADDR_W(5), .BIT_WIDTH(9), .FRACTION_WIDTH(4),
        .NUM_IN(8), .NUM_OUT(3), .TIMEOUT_CYCLES(1024)
    ) dut_b (
        .clock        (clk),
        .reset        (rst_b),
        .bus          (bus_b),
        .irq          (irq_b),
        .core_start   (core_start_b),
        .core_done    (core_done_b),
        .core_inputs  (core_inputs_b),
        .core_outputs (core_outputs_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic bus_idle();
        bus_a.address = '0; bus_a.chipselect = 1'b0; bus_a.write = 1'b0;
        bus_a.read = 1'b0; bus_a.writedata = '0;
        bus_b.address = '0; bus_b.chipselect = 1'b0; bus_b.write = 1'b0;
        bus_b.read = 1'b0; bus_b.writedata = '0;
    endtask

    // Called at a negedge; the access is sampled on the following posedge.
    task automatic bus_write(input bit sel, input int unsigned addr, input logic [31:0] data);
        if (!sel) begin
            bus_a.address = 5'(addr); bus_a.chipselect = 1'b1;
            bus_a.write = 1'b1; bus_a.writedata = data;
        end else begin
            bus_b.address = 5'(addr); bus_b.chipselect = 1'b1;
            bus_b.write = 1'b1; bus_b.writedata = data;
        end
        @(negedge clk);
        bus_idle();
    endtask

    task automatic rd_chk(input bit sel, input int unsigned addr, input logic [31:0] exp_v,
                          input string tag);
        if (!sel) begin
            bus_a.address = 5'(addr); bus_a.chipselect = 1'b1; bus_a.read = 1'b1;
        end else begin
            bus_b.address = 5'(addr); bus_b.chipselect = 1'b1; bus_b.read = 1'b1;
        end
        @(negedge clk);
        bus_idle();
        chk(tag, sel ? 128'(bus_b.readdata) : 128'(bus_a.readdata), 128'(exp_v));
    endtask

    initial begin
        clk = 1'b0;
        rst_a = 1'b1; rst_b = 1'b1;
        core_done_a = 1'b0; core_done_b = 1'b0;
        core_outputs_a = 9'h1A5;
        core_outputs_b = {9'h1FE, 9'h13C, 9'h0C3};
        vin  = '{9'h000, 9'h0FF, 9'h100, 9'h1FF, 9'h001, 9'h0AB, 9'h155, 9'h17E};
        vexp = '{32'h0000_0000, 32'h0000_00FF, 32'hFFFF_FF00, 32'hFFFF_FFFF,
                 32'h0000_0001, 32'h0000_00AB, 32'hFFFF_FF55, 32'hFFFF_FF7E};
        bus_idle();
        repeat (2) @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;

        // Reset state
        chk("rst_readdata", 128'(bus_a.readdata), 128'h0);
        chk("rst_irq", 128'(irq_a), 128'h0);
        chk("rst_core_start", 128'(core_start_a), 128'h0);
        chk("rst_core_inputs", 128'(core_inputs_a), 128'h0);
        rd_chk(0, 1, 32'h0, "rst_status");
        rd_chk(0, 2, 32'h0, "rst_cycles");
        rd_chk(0, 6, 32'h0, "rst_out0");

        // Basic run: done 5 cycles after core_start
        bus_write(0, 4, 32'h1F0);
        bus_write(0, 5, 32'h012);
        chk("in_packed", 128'(core_inputs_a), 128'h25F0);
        bus_write(0, 0, 32'h1);
        chk("start_pulse_hi", 128'(core_start_a), 128'h1);
        @(negedge clk);
        chk("start_pulse_lo", 128'(core_start_a), 128'h0);
        repeat (4) @(negedge clk);
        core_done_a = 1'b1;
        @(negedge clk);
        core_done_a = 1'b0;
        rd_chk(0, 1, 32'h2, "run1_status");
        rd_chk(0, 2, 32'd5, "run1_cycles");
        rd_chk(0, 6, 32'hFFFF_FFA5, "run1_out0");
        rd_chk(0, 4, 32'hFFFF_FFF0, "run1_in0");
        rd_chk(0, 5, 32'h0000_0012, "run1_in1");
        rd_chk(0, 0, 32'h0, "run1_ctrl");

        // Interrupt set on done, dropped by CLR
        bus_write(0, 0, 32'h6);
        chk("irq_after_clr", 128'(irq_a), 128'h0);
        rd_chk(0, 0, 32'h2, "irq_en_readback");
        rd_chk(0, 1, 32'h0, "irq_status_clr");
        core_outputs_a = 9'h07F;
        bus_write(0, 0, 32'h3);
        @(negedge clk);
        @(negedge clk);
        chk("irq_before_done", 128'(irq_a), 128'h0);
        core_done_a = 1'b1;
        @(negedge clk);
        core_done_a = 1'b0;
        chk("irq_after_done", 128'(irq_a), 128'h1);
        rd_chk(0, 1, 32'h2, "irq_status_done");
        bus_write(0, 0, 32'h6);
        chk("irq_cleared", 128'(irq_a), 128'h0);
        rd_chk(0, 1, 32'h0, "irq_status_cleared");
        rd_chk(0, 6, 32'h0000_007F, "irq_out0");

        // Writes during RUN set ERR and are otherwise ignored
        core_outputs_a = 9'h100;
        bus_write(0, 0, 32'h1);
        chk("busy_start", 128'(core_start_a), 128'h1);
        bus_write(0, 4, 32'h055);
        bus_write(0, 0, 32'h1);
        chk("busy_no_restart", 128'(core_start_a), 128'h0);
        chk("busy_inputs_frozen", 128'(core_inputs_a), 128'h25F0);
        rd_chk(0, 1, 32'h9, "busy_status_run");
        chk("busy_no_restart2", 128'(core_start_a), 128'h0);
        core_done_a = 1'b1;
        @(negedge clk);
        core_done_a = 1'b0;
        rd_chk(0, 1, 32'hA, "busy_status_end");
        rd_chk(0, 2, 32'd3, "busy_cycles");
        rd_chk(0, 6, 32'hFFFF_FF00, "busy_out0");
        rd_chk(0, 4, 32'hFFFF_FFF0, "busy_in0");

        // Timeout after 16 RUN cycles with no core_done
        bus_write(0, 0, 32'h4);
        rd_chk(0, 1, 32'h0, "to_status_clr");
        core_outputs_a = 9'h0AA;
        bus_write(0, 0, 32'h1);
        repeat (15) @(negedge clk);
        rd_chk(0, 1, 32'h1, "to_still_busy");
        rd_chk(0, 1, 32'h4, "to_status");
        rd_chk(0, 6, 32'hFFFF_FF00, "to_out0_kept");
        rd_chk(0, 2, 32'd3, "to_cycles_kept");
        bus_write(0, 0, 32'h1);
        chk("to_restart", 128'(core_start_a), 128'h1);
        @(negedge clk);
        core_done_a = 1'b1;
        @(negedge clk);
        core_done_a = 1'b0;
        rd_chk(0, 2, 32'd1, "to_rerun_cycles");
        rd_chk(0, 6, 32'h0000_00AA, "to_rerun_out0");
        rd_chk(0, 1, 32'h6, "to_rerun_status");

        // CLR coincident with core_done leaves DONE set
        bus_write(0, 0, 32'h1);
        bus_a.address = 5'd0; bus_a.chipselect = 1'b1; bus_a.write = 1'b1;
        bus_a.writedata = 32'h4;
        core_done_a = 1'b1;
        @(negedge clk);
        bus_idle();
        core_done_a = 1'b0;
        rd_chk(0, 1, 32'h2, "coin_status");
        rd_chk(0, 2, 32'd0, "coin_cycles");

        // core_done while IDLE is ignored
        core_outputs_a = 9'h155;
        core_done_a = 1'b1;
        @(negedge clk);
        core_done_a = 1'b0;
        rd_chk(0, 6, 32'h0000_00AA, "idle_done_out0");
        rd_chk(0, 1, 32'h2, "idle_done_status");
        rd_chk(0, 2, 32'd0, "idle_done_cycles");

        // Reserved and unmapped addresses
        bus_write(0, 3, 32'hFFFF_FFFF);
        rd_chk(0, 3, 32'h0, "reserved_addr3");
        rd_chk(0, 7, 32'h0, "unmapped_addr7");

        // Wide instance: 8 inputs, 3 outputs
        for (int i = 0; i < 8; i++) bus_write(1, 32'(4 + i), 32'(vin[i]));
        for (int i = 0; i < 8; i++) rd_chk(1, 32'(4 + i), vexp[i], $sformatf("b_in%0d", i));
        for (int i = 0; i < 8; i++)
            chk($sformatf("b_pin%0d", i), 128'(core_inputs_b[i*9 +: 9]), 128'(vin[i]));
        bus_write(1, 0, 32'h1);
        chk("b_start", 128'(core_start_b), 128'h1);
        @(negedge clk);
        @(negedge clk);
        core_done_b = 1'b1;
        @(negedge clk);
        core_done_b = 1'b0;
        rd_chk(1, 12, 32'h0000_00C3, "b_out0");
        rd_chk(1, 13, 32'hFFFF_FF3C, "b_out1");
        rd_chk(1, 14, 32'hFFFF_FFFE, "b_out2");
        rd_chk(1, 15, 32'h0, "b_addr15");
        rd_chk(1, 1, 32'h2, "b_status");
        rd_chk(1, 2, 32'd2, "b_cycles");

        // Reset in the middle of a run
        bus_write(1, 0, 32'h3);
        chk("b_start2", 128'(core_start_b), 128'h1);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        chk("b_rst_core_start", 128'(core_start_b), 128'h0);
        chk("b_rst_irq", 128'(irq_b), 128'h0);
        chk("b_rst_readdata", 128'(bus_b.readdata), 128'h0);
        chk("b_rst_inputs", 128'(core_inputs_b), 128'h0);
        core_outputs_b = {9'h011, 9'h022, 9'h033};
        core_done_b = 1'b1;
        @(negedge clk);
        core_done_b = 1'b0;
        rd_chk(1, 1, 32'h0, "b_rst_status");
        rd_chk(1, 2, 32'h0, "b_rst_cycles");
        rd_chk(1, 12, 32'h0, "b_rst_out0");
        rd_chk(1, 14, 32'h0, "b_rst_out2");
        rd_chk(1, 4, 32'h0, "b_rst_in0");
        rd_chk(1, 0, 32'h0, "b_rst_ctrl");
        chk("b_rst_irq_late", 128'(irq_b), 128'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
